// File: rtl/bench_seq_pipe_pkg.sv
// Shared definitions for bench_seq_pipe: mode encoding, default MISR
// polynomial and the per-bit logic function applied to each accepted word.
package bench_pkg;

    // Mode encoding, sampled together with each input word.
    localparam logic MODE_BASE = 1'b0;
    localparam logic MODE_XOR  = 1'b1;

    // Widest input word the shared function can address.
    localparam int BENCH_MAX_W = 64;
    localparam int BENCH_IDX_W = $clog2(BENCH_MAX_W);

    // Default MISR feedback polynomial for the 25-bit output word.
    localparam logic [24:0] BENCH_POLY_DEFAULT = 25'h0000009;

    // One output bit of the benchmark function. The caller zero-extends the
    // input word to BENCH_MAX_W and passes its real width in in_w, so bit
    // indices wrap modulo the real width rather than the extended one.
    function automatic logic bench_func(
        input logic [BENCH_MAX_W-1:0] din,
        input logic                   mode,
        input int                     bit_idx,
        input int                     in_w
    );
        logic                   f;
        logic [BENCH_IDX_W-1:0] idx_a;
        logic [BENCH_IDX_W-1:0] idx_b;
        idx_a = BENCH_IDX_W'(bit_idx % in_w);
        idx_b = BENCH_IDX_W'((bit_idx + 1) % in_w);
        if (bit_idx == 0) begin
            f = din[0] & din[1];
        end else if (bit_idx == 1) begin
            f = din[0] | din[1];
        end else if (mode == MODE_BASE) begin
            f = ~din[idx_a];
        end else begin
            f = din[idx_a] ^ din[idx_b];
        end
        return f;
    endfunction

endpackage

// File: rtl/bench_seq_pipe_if.sv
// Valid/ready stream bundle for bench_seq_pipe: the input word channel and
// the result word channel. The pipeline takes the slave view; the
// producer/consumer around it takes the master view.
interface bench_seq_pipe_if #(
    parameter int IN_W  = 33,
    parameter int OUT_W = 25
);

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

endinterface

// File: rtl/bench_seq_pipe_stage.sv
// bench_pipe_stage: one elastic register slice (data + valid). The slice
// loads whenever it is empty or its downstream neighbour is taking its
// current word, so a chain of slices runs at one word per cycle and stalls
// without dropping or duplicating words.
module bench_pipe_stage #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         up_vld,
    input  logic [W-1:0] up_data,
    output logic         up_ready,
    input  logic         down_ready,
    output logic         vld,
    output logic [W-1:0] data
);

    // The slice can take a word when empty or when its word is leaving.
    assign up_ready = !vld || down_ready;

    // Valid flag: cleared by reset or clr, otherwise follows upstream on load.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the slices update in parallel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
        end else if (clr) begin
            vld <= 1'b0;
        end else if (up_ready) begin
            vld <= up_vld;
        end
    end

    // Data register: captured only for real words, held while stalled.
    // NOTE: the data register is reset as well so out_data reads 0 after
    // reset; clr leaves it alone because the cleared valid hides it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (up_ready && up_vld) begin
            data <= up_data;
        end
    end

endmodule

// File: rtl/bench_seq_pipe.sv
// bench_seq_pipe: sequential benchmark host. Each accepted IN_W-bit word is
// mapped through the mode-selected bench_func, carried through STAGES
// elastic slices, and every completed output transfer is counted.
// Optional feature macro: BENCH_SEQ_PIPE_MISR_EN -- when defined, a MISR
// folds every transferred output word into sig; otherwise sig is tied 0.
module bench_seq_pipe
    import bench_pkg::*;
#(
    parameter int               IN_W   = 33,
    parameter int               OUT_W  = 25,
    parameter int               STAGES = 2,
    parameter int               CNT_W  = 16,
    parameter logic [OUT_W-1:0] POLY   = BENCH_POLY_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 mode,
    bench_seq_pipe_if.slave      bus,
    output logic [CNT_W-1:0]     xfer_cnt,
    output logic [OUT_W-1:0]     sig
);

    // Input word widened to the function's addressing width.
    logic [BENCH_MAX_W-1:0] din_ext;
    logic [OUT_W-1:0]       func;

    // Per-position valid / ready / data along the chain; index 0 is the
    // input side, index STAGES is the output side.
    logic [STAGES:0]        vld_chain;
    logic [STAGES:0]        rdy_chain;
    logic [OUT_W-1:0]       data_chain [STAGES+1];

    logic                   xfer;

    assign din_ext = BENCH_MAX_W'(bus.in_data);

    // Function bits, one per output position, from the word and its mode.
    for (genvar i = 0; i < OUT_W; i++) begin : g_func
        assign func[i] = bench_func(din_ext, mode, i, IN_W);
    end

    assign vld_chain[0]      = bus.in_valid;
    assign data_chain[0]     = func;
    assign rdy_chain[STAGES] = bus.out_ready;

    // Elastic slices; each one's ready feeds the slice before it, so a full
    // pipeline with out_ready high accepts and emits on the same cycle.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        bench_pipe_stage #(
            .W (OUT_W)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr        (clr),
            .up_vld     (vld_chain[k]),
            .up_data    (data_chain[k]),
            .up_ready   (rdy_chain[k]),
            .down_ready (rdy_chain[k+1]),
            .vld        (vld_chain[k+1]),
            .data       (data_chain[k+1])
        );
    end

    assign bus.in_ready  = rdy_chain[0];
    assign bus.out_valid = vld_chain[STAGES];
    assign bus.out_data  = data_chain[STAGES];

    assign xfer = vld_chain[STAGES] && bus.out_ready;

    // Saturating count of output transfers; clr wins over a same-cycle
    // transfer, which is therefore not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (clr) begin
            xfer_cnt <= '0;
        end else if (xfer && (xfer_cnt != {CNT_W{1'b1}})) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

`ifdef BENCH_SEQ_PIPE_MISR_EN
    // Signature: shift, fold in POLY when the MSB falls out, mix the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (xfer) begin
            sig <= (sig << 1) ^ (sig[OUT_W-1] ? POLY : '0) ^ data_chain[STAGES];
        end
    end
`else
    // No signature register; POLY is masked away but still referenced so
    // both builds accept the same parameter set.
    assign sig = POLY & {OUT_W{1'b0}};
`endif

endmodule

// File: tb/tb_bench_seq_pipe.sv
// Self-checking bench for bench_seq_pipe: directed cases for latency,
// back-to-back flow, stall, reset and clr, plus a randomized run. A
// queue-based reference model checks ordering, data, in_ready, the
// saturating counters of two DUTs (CNT_W=16 and CNT_W=4) and the signature.
module tb_bench_seq_pipe;

    localparam int               IN_W   = 33;
    localparam int               OUT_W  = 25;
    localparam int               STAGES = 2;
    localparam int               CNT_W  = 16;
    localparam logic [OUT_W-1:0] POLY   = 25'h0000009;
    localparam int               IW     = $clog2(IN_W);

    logic clk;
    logic rst_n;
    logic clr;
    logic mode;
    logic [CNT_W-1:0] xfer_cnt;
    logic [OUT_W-1:0] sig;
    logic [3:0]       xfer_cnt4;
    logic [OUT_W-1:0] sig4;

    int checks   = 0;
    int failures = 0;

    bench_seq_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) pif ();
    bench_seq_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) pif4 ();

    bench_seq_pipe #(
        .IN_W(IN_W), .OUT_W(OUT_W), .STAGES(STAGES), .CNT_W(CNT_W), .POLY(POLY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .bus(pif),
        .xfer_cnt(xfer_cnt), .sig(sig)
    );

    // Second copy with a 4-bit counter sees the same stream.
    assign pif4.in_valid  = pif.in_valid;
    assign pif4.in_data   = pif.in_data;
    assign pif4.out_ready = pif.out_ready;

    bench_seq_pipe #(
        .IN_W(IN_W), .OUT_W(OUT_W), .STAGES(STAGES), .CNT_W(4), .POLY(POLY)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .bus(pif4),
        .xfer_cnt(xfer_cnt4), .sig(sig4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference function straight from the bit rules.
    function automatic logic [OUT_W-1:0] ref_f(input logic [IN_W-1:0] x, input logic m);
        logic [OUT_W-1:0] f;
        logic [IW-1:0]    a;
        logic [IW-1:0]    b;
        f = '0;
        for (int i = 0; i < OUT_W; i++) begin
            a = IW'(i % IN_W);
            b = IW'((i + 1) % IN_W);
            if (i == 0)      f[i] = x[0] & x[1];
            else if (i == 1) f[i] = x[0] | x[1];
            else if (m)      f[i] = x[a] ^ x[b];
            else             f[i] = ~x[a];
        end
        return f;
    endfunction

    // ---------------- reference model ----------------
    logic [OUT_W-1:0] q[$];
    int               m_cnt  = 0;
    int               m_cnt4 = 0;
    logic [OUT_W-1:0] m_sig  = '0;
    logic             stall_prev = 1'b0;
    logic [OUT_W-1:0] held;

    // Mid-cycle sampling: compare current outputs, then apply the effects
    // of the coming rising edge to the model.
    always @(negedge clk) begin
        logic [OUT_W-1:0] exp_w;
        logic             do_xfer;
        logic             do_acc;
        if (!rst_n) begin
            q.delete();
            m_cnt      = 0;
            m_cnt4     = 0;
            m_sig      = '0;
            stall_prev = 1'b0;
        end else begin
            check("in_ready", pif.in_ready, (q.size() < STAGES) || pif.out_ready);
            if (q.size() == 0) check("empty_out_valid", pif.out_valid, 1'b0);
            check("xfer_cnt", xfer_cnt, m_cnt);
            check("xfer_cnt4", xfer_cnt4, m_cnt4);
            check("sig", sig, m_sig);
            check("sig4", sig4, m_sig);
            if (stall_prev) begin
                check("stall_valid_hold", pif.out_valid, 1'b1);
                check("stall_data_hold", pif.out_data, held);
            end
            do_xfer = pif.out_valid && pif.out_ready;
            do_acc  = pif.in_valid && pif.in_ready;
            exp_w   = '0;
            if (do_xfer) begin
                check("xfer_has_word", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    exp_w = q.pop_front();
                    check("out_data", pif.out_data, exp_w);
                end
            end
            if (clr) begin
                q.delete();
                m_cnt      = 0;
                m_cnt4     = 0;
                m_sig      = '0;
                stall_prev = 1'b0;
            end else begin
                if (do_xfer) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt4 < 15) m_cnt4++;
`ifdef BENCH_SEQ_PIPE_MISR_EN
                    m_sig = (m_sig << 1) ^ (m_sig[OUT_W-1] ? POLY : '0) ^ exp_w;
`endif
                end
                if (do_acc) q.push_back(ref_f(pif.in_data, mode));
                stall_prev = pif.out_valid && !pif.out_ready;
                held       = pif.out_data;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!pif.out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!pif.out_valid) check(tag, 1'b0, 1'b1);
    endtask

    task automatic send_one(input logic [IN_W-1:0] d, input logic m);
        int n;
        pif.in_valid = 1'b1;
        pif.in_data  = d;
        mode         = m;
        n = 0;
        while (!pif.in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!pif.in_ready) check("send_ready_timeout", 1'b0, 1'b1);
        tick();
        pif.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || pif.out_valid) && n < 40) begin
            tick();
            n++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    logic [IN_W-1:0] ones;
    int              accepts;

    initial begin
        rst_n         = 1'b0;
        clr           = 1'b0;
        mode          = 1'b0;
        pif.in_valid  = 1'b0;
        pif.in_data   = '0;
        pif.out_ready = 1'b0;
        ones          = '1;
        tick();
        tick();

        // Reset state.
        check("rst_out_valid", pif.out_valid, 1'b0);
        check("rst_in_ready", pif.in_ready, 1'b1);
        check("rst_xfer_cnt", xfer_cnt, 0);
        check("rst_out_data", pif.out_data, 0);
        check("rst_sig", sig, 0);
        rst_n = 1'b1;
        tick();

        // Single word, exact latency.
        pif.out_ready = 1'b1;
        pif.in_valid  = 1'b1;
        pif.in_data   = '0;
        mode          = 1'b0;
        check("lat_in_ready", pif.in_ready, 1'b1);
        tick();
        pif.in_valid = 1'b0;
        for (int s = 1; s < STAGES; s++) begin
            check("lat_early_valid", pif.out_valid, 1'b0);
            tick();
        end
        check("lat_out_valid", pif.out_valid, 1'b1);
        check("lat_out_data", pif.out_data, 25'h1FFFFFC);
        tick();
        check("lat_xfer_cnt", xfer_cnt, 1);
        check("lat_after_valid", pif.out_valid, 1'b0);
`ifdef BENCH_SEQ_PIPE_MISR_EN
        check("sig_first", sig, 25'h1FFFFFC);
`endif

        // Mode 1 words.
        send_one('0, 1'b1);
        wait_out("m1_zero_timeout");
        check("m1_zero", pif.out_data, 25'h0000000);
        tick();
`ifdef BENCH_SEQ_PIPE_MISR_EN
        check("sig_second", sig, 25'h1FFFFF1);
`endif
        send_one(ones, 1'b1);
        wait_out("m1_ones_timeout");
        check("m1_ones", pif.out_data, 25'h0000003);
        tick();

        // Back-to-back mode 0.
        mode         = 1'b0;
        pif.in_valid = 1'b1;
        pif.in_data  = 33'h3;
        check("b2b_ready0", pif.in_ready, 1'b1);
        tick();
        pif.in_data = 33'h1;
        check("b2b_ready1", pif.in_ready, 1'b1);
        tick();
        pif.in_valid = 1'b0;
        wait_out("b2b_timeout");
        check("b2b_word0", pif.out_data, 25'h1FFFFFF);
        tick();
        check("b2b_valid1", pif.out_valid, 1'b1);
        check("b2b_word1", pif.out_data, 25'h1FFFFFE);
        tick();

        // Backpressure: pipeline fills, then drains in order.
        pif.out_ready = 1'b0;
        accepts = 0;
        for (int c = 0; c < 5; c++) begin
            pif.in_valid = 1'b1;
            pif.in_data  = IN_W'({$urandom(), $urandom()});
            mode         = 1'($urandom_range(0, 1));
            if (pif.in_ready) accepts++;
            tick();
        end
        pif.in_valid = 1'b0;
        check("stall_accepts", accepts, STAGES);
        check("full_in_ready", pif.in_ready, 1'b0);
        check("full_out_valid", pif.out_valid, 1'b1);
        pif.out_ready = 1'b1;
        drain();

        // Asynchronous reset with words in flight.
        for (int c = 0; c < 3; c++) begin
            pif.in_valid = 1'b1;
            pif.in_data  = IN_W'({$urandom(), $urandom()});
            tick();
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", pif.out_valid, 1'b0);
        check("arst_xfer_cnt", xfer_cnt, 0);
        check("arst_in_ready", pif.in_ready, 1'b1);
        pif.in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // clr during a transfer: that transfer is not counted.
        for (int c = 0; c < 3; c++) begin
            pif.in_valid = 1'b1;
            pif.in_data  = IN_W'({$urandom(), $urandom()});
            tick();
        end
        pif.in_valid = 1'b0;
        check("clr_pre_valid", pif.out_valid, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_cnt", xfer_cnt, 0);
        check("clr_valid", pif.out_valid, 1'b0);
        check("clr_sig", sig, 0);
        tick();

        // Randomized traffic with occasional clr.
        for (int c = 0; c < 400; c++) begin
            pif.in_valid  = 1'($urandom_range(0, 1));
            pif.in_data   = IN_W'({$urandom(), $urandom()});
            mode          = 1'($urandom_range(0, 1));
            pif.out_ready = ($urandom_range(0, 3) != 0);
            clr           = ($urandom_range(0, 40) == 0);
            tick();
        end
        clr           = 1'b0;
        pif.in_valid  = 1'b0;
        pif.out_ready = 1'b1;
        drain();

        // Saturation of the 4-bit counter.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int c = 0; c < 20; c++) begin
            pif.in_valid = 1'b1;
            pif.in_data  = IN_W'({$urandom(), $urandom()});
            mode         = 1'($urandom_range(0, 1));
            tick();
        end
        pif.in_valid = 1'b0;
        drain();
        check("sat_cnt4", xfer_cnt4, 4'hF);
        check("cnt_20", xfer_cnt, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bench_seq_pipe.md
Name: bench_seq_pipe

Overview:
- Parametrised sequential successor to the generic combinational benchmark (bench_comb) used as a trojan-insertion host.
- Applies the same style of logic function, selectable by mode, to IN_W-bit input words.
- Carries results through a STAGES-deep elastic valid/ready pipeline.
- Counts completed transfers and can optionally accumulate a MISR signature for golden-vs-suspect comparison.

Parameters:
- IN_W, 33, input word width (>=2)
- OUT_W, 25, output word width (>=2)
- STAGES, 2, pipeline register stages (>=1)
- CNT_W, 16, transfer counter width
- POLY, 25'h0000009, MISR feedback polynomial (OUT_W bits; used only with the optional feature)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of counter, pipeline valids and signature
- mode  in  1  0 = base function, 1 = xor function
- in_valid  in  1  input word valid
- in_ready  out  1  pipeline can accept
- in_data  in  IN_W  input word
- out_valid  out  1  output word valid
- out_ready  in  1  sink accepts
- out_data  out  OUT_W  result word
- xfer_cnt  out  CNT_W  completed output transfers, saturating
- sig  out  OUT_W  MISR signature (tied 0 without the feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Function, evaluated combinationally on in_data and mode at accept, then registered:
  - f[0] = in[0] & in[1]
  - f[1] = in[0] | in[1]
  - for i >= 2, mode 0: f[i] = ~in[i % IN_W]
  - for i >= 2, mode 1: f[i] = in[i % IN_W] ^ in[(i+1) % IN_W]
  - mode is sampled with the word; changing mode mid-stream affects only newly accepted words.
- Pipeline:
  - Stage k holds data_k and vld_k.
  - Stage k loads when vld_k == 0 or stage k is advancing.
  - Last stage advances on out_valid & out_ready; stage k advances when stage k+1 loads.
  - in_ready = !vld_0 | advance_0, purely combinational from state and out_ready.
  - Accept = in_valid & in_ready.
- Latency and throughput:
  - Exactly STAGES cycles from accept edge to out_valid with no backpressure.
  - Throughput 1 word/cycle.
  - Full pipeline with out_ready = 1 accepts and emits on the same cycle.
- Stall rules:
  - out_valid = vld_last.
  - out_data stable while out_valid & !out_ready.
  - Words are never dropped or duplicated; output order equals acceptance order.
- Full condition: all vld = 1 and out_ready = 0 gives in_ready = 0.
- Empty condition: all vld = 0 gives out_valid = 0 and in_ready = 1.
- xfer_cnt:
  - +1 per output transfer; saturates at all-ones and holds.
- clr:
  - Takes priority over all other updates; next cycle has all vld, xfer_cnt and sig at 0.
  - A transfer in the clr cycle is not counted.
  - Data registers need not clear.
- Reset, including assertion mid-operation:
  - vld_*, out_valid, xfer_cnt and sig go to 0 immediately.
  - in_ready = 1 when reset is released.
  - out_data resets to 0.

Optional Feature:
- Macro: BENCH_SEQ_PIPE_MISR_EN.
- Defined: on each output transfer, sig <= (sig << 1) ^ (sig[OUT_W-1] ? POLY : 0) ^ out_data. The register is cleared by reset or clr.
- Undefined: sig is constant 0 and no signature register is synthesised.

Decomposition:
- Package bench_pkg holds:
  - mode encoding constants MODE_BASE = 1'b0, MODE_XOR = 1'b1
  - default POLY constant
  - function bench_func(in, mode), parametrised via package-level width constants or elaborated in the module
- Natural sub-module: bench_pipe_stage, one elastic register slice (data + vld, load/advance logic), instantiated STAGES times by generate.

Test Plan (IN_W=33, OUT_W=25, STAGES=2):
- Reset then single word, mode 0, in=33'h0 -> out_valid exactly 2 cycles after accept, out_data=25'h1FFFFFC, xfer_cnt=1.
- Mode 0 in=33'h3, then 33'h1 back-to-back -> out_data 25'h1FFFFFF then 25'h1FFFFFE on consecutive cycles, in_ready held 1.
- Mode 1 in=33'h1FFFFFFFF -> 25'h0000003; mode 1 in=0 -> 25'h0000000.
- out_ready=0 for 5 cycles with in_valid=1 -> in_ready drops after 2 accepts, out_data stable; release -> all words arrive in order, none lost.
- rst_n asserted mid-stream with words in flight -> out_valid=0 and xfer_cnt=0 asynchronously; clr pulse during a transfer -> that transfer is not counted.
- With BENCH_SEQ_PIPE_MISR_EN: from reset, one transfer of 25'h1FFFFFC -> sig=25'h1FFFFFC; a second of 25'h0000000 -> sig=25'h1FFFFF1. Counter forced near saturation (CNT_W=4, 17 transfers) -> xfer_cnt=4'hF.
